memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory_pkg.sv | 14 +
 rtl/memory.sv | 44 ++++
 tb/tb_memory.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared defaults and cell-encoding constants for the memory block
package memory_pkg;

    localparam int DATA_W_DEF = 2;
    localparam int ADDR_W_DEF = 7;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    // Cell contents are stored opaquely; these encodings belong to the client.
    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_HIT   = 2'b10;
    localparam logic [1:0] CELL_MISS  = 2'b11;

endpackage

// File: rtl/memory.sv
// rtl/memory.sv - register-array memory with one-cycle registered read onto a tristate bus
module memory
    import memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] addr,
    inout  logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              drive_bus;

    // A write always wins over a read so the block never fights the write driver.
    assign drive_bus = oe && !we;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (drive_bus) begin
            rdata_q <= mem[addr];
        end
    end

    assign data = drive_bus ? rdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - scoreboard bench for the memory block
module tb_memory;
    import memory_pkg::*;

    localparam int DW = 2;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic          oe = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          drv_en = 1'b0;
    logic [DW-1:0] drv_val = '0;
    tri1  [DW-1:0] data;

    // A released bus is pulled to all ones, so any DUT drive of 00/01/10 shows up.
    assign data = drv_en ? drv_val : {DW{1'bz}};

    always #5 clk = ~clk;

    memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1 << AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .oe    (oe),
        .addr  (addr),
        .data  (data)
    );

    typedef struct {
        string         name;
        logic          chk;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            if (cur.chk) begin
                total++;
                if (data !== cur.exp) begin
                    bad++;
                    $display("FAIL %s: addr=%h got=%b want=%b", cur.name, addr, data, cur.exp);
                end
            end
        end
    end

    task automatic step(input logic r, input logic w, input logic o, input logic [AW-1:0] a,
                        input logic de, input logic [DW-1:0] dv,
                        input logic c, input logic [DW-1:0] e, input string n);
        @(negedge clk);
        rst_n   = r;
        we      = w;
        oe      = o;
        addr    = a;
        drv_en  = de;
        drv_val = dv;
        sbq.push_back('{name: n, chk: c, exp: e});
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e, input string n);
        step(1'b1, 1'b0, 1'b1, a, 1'b0, '0, 1'b1, e, n);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] v);
        step(1'b1, 1'b1, 1'b0, a, 1'b1, v, 1'b0, '0, "wr");
    endtask

    task automatic idle_chk(input string n);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 2'b11, n);
    endtask

    initial begin
        // Reset held two clocks with a read pending: bus shows the cleared read register.
        step(1'b0, 1'b0, 1'b1, 7'h00, 1'b0, '0, 1'b1, 2'b00, "rst_drive0");
        step(1'b0, 1'b0, 1'b1, 7'h00, 1'b0, '0, 1'b1, 2'b00, "rst_drive1");

        for (int i = 0; i < (1 << AW); i++) begin
            rd(AW'(i), CELL_EMPTY, "sweep");
        end

        idle_chk("release_idle0");

        wr(7'h00, CELL_EMPTY);
        wr(7'h09, CELL_SHIP);
        wr(7'h02, CELL_HIT);
        wr(7'h17, CELL_MISS);

        rd(7'h00, 2'b00, "burst_00");
        rd(7'h09, 2'b01, "burst_09");
        rd(7'h17, 2'b11, "burst_17");
        rd(7'h02, 2'b10, "burst_02");

        // rdata_q now holds 10, so an improper drive would pull the bus low.
        idle_chk("release_idle1");

        // we+oe with the bench released: bus must stay at the pull level; stores 11.
        step(1'b1, 1'b1, 1'b1, 7'h06, 1'b0, '0, 1'b1, 2'b11, "contend_hiz");
        step(1'b1, 1'b1, 1'b1, 7'h05, 1'b1, 2'b10, 1'b0, '0, "contend_wr");
        rd(7'h05, 2'b10, "contend_rd05");
        rd(7'h06, 2'b11, "contend_rd06");

        wr(7'h40, 2'b01);
        wr(7'h40, 2'b11);
        rd(7'h40, 2'b11, "overwrite");

        wr(7'h33, 2'b10);
        rd(7'h33, 2'b10, "wr_then_rd");

        wr(7'h7F, 2'b11);
        rd(7'h7F, 2'b11, "pre_rst_7f");
        step(1'b0, 1'b0, 1'b0, 7'h00, 1'b0, '0, 1'b0, '0, "mid_rst");
        rd(7'h7F, 2'b00, "post_rst_7f");
        rd(7'h09, 2'b00, "post_rst_09");

        // Writes during reset are ignored.
        step(1'b0, 1'b1, 1'b0, 7'h10, 1'b1, 2'b11, 1'b0, '0, "rst_wr");
        rd(7'h10, 2'b00, "rst_wr_ignored");

        // Reset with a read pending clears rdata_q and does not capture the cell.
        wr(7'h17, 2'b11);
        rd(7'h17, 2'b11, "pre_rst_17");
        step(1'b0, 1'b0, 1'b1, 7'h17, 1'b0, '0, 1'b1, 2'b00, "rst_clears_rdata");
        rd(7'h17, 2'b00, "post_rst_17");

        @(negedge clk);
        oe = 1'b0;
        we = 1'b0;
        for (int i = 0; i < 10 && sbq.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
